gbm_path_scheduler: RTL and testbench

Sequences one shared GBM step datapath across `N_PATHS` Monte-Carlo paths and `N_STEPS` time steps. Holds each path's current price, pulls normal variates from the QMC normal generator, issues one GBM step per cycle under an in-flight credit limit, and writes results back. Streams every (path, step, price) tuple to the LSM regression buffer. Sits between the QMC/normal front end and the LSM back end.

---
 rtl/gbm_path_scheduler.sv | 143 ++++++++++++++
 tb/tb_gbm_path_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gbm_path_scheduler.sv
// gbm_path_scheduler: shares one GBM step unit across N_PATHS paths x N_STEPS steps under an in-flight credit limit.
// Optional macro GBM_SCHED_ANTITHETIC_EN: odd paths reuse the preceding even path's variate, saturating-negated.
module gbm_path_scheduler #(
    parameter int WIDTH        = 32,
    parameter int N_PATHS      = 64,
    parameter int N_STEPS      = 16,
    parameter int MAX_INFLIGHT = 8,
    localparam int PW = $clog2(N_PATHS),
    localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_s0,
    input  logic [WIDTH-1:0] cfg_r,
    input  logic [WIDTH-1:0] cfg_sigma,
    input  logic [WIDTH-1:0] cfg_dt,
    input  logic             z_valid,
    input  logic [WIDTH-1:0] z_data,
    output logic             z_ready,
    output logic             gbm_valid_in,
    output logic [WIDTH-1:0] gbm_z,
    output logic [WIDTH-1:0] gbm_s0,
    output logic [WIDTH-1:0] gbm_r,
    output logic [WIDTH-1:0] gbm_sigma,
    output logic [WIDTH-1:0] gbm_t,
    input  logic             gbm_valid_out,
    input  logic [WIDTH-1:0] gbm_s1,
    output logic             res_valid,
    output logic [PW-1:0]    res_path,
    output logic [SW-1:0]    res_step,
    output logic [WIDTH-1:0] res_price,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int FW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [PW-1:0] LAST_PATH = PW'(N_PATHS - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);
    localparam logic [FW-1:0] LAST_SLOT = FW'(MAX_INFLIGHT - 1);
    localparam logic [IW-1:0] CREDITS   = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    path;
    logic [SW-1:0]    step;
    logic [IW-1:0]    inflight;
    logic [FW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] s0_q, z_issue;
    logic [WIDTH-1:0] price [N_PATHS];
    logic [PW-1:0]    tag_mem [MAX_INFLIGHT];
    logic             slot_open, need_z, fire, pop;

    assign slot_open = (state == S_ISSUE) && (inflight < CREDITS);
    assign fire      = slot_open && (z_valid || !need_z);
    // inflight doubles as the tag FIFO occupancy, so a return with it at zero is spurious
    assign pop       = gbm_valid_out && (inflight != '0);

`ifdef GBM_SCHED_ANTITHETIC_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] z_hold;
    assign need_z  = ~path[0];
    assign z_issue = need_z ? z_data : (z_hold == MOST_NEG) ? ~MOST_NEG : -z_hold;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) z_hold <= '0;
        else if (fire && need_z) z_hold <= z_data;
`else
    assign need_z  = 1'b1;
    assign z_issue = z_data;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        z_ready   = slot_open && need_z;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:  state_nxt = start ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nxt = (fire && path == LAST_PATH) ? S_DRAIN : S_ISSUE;
            S_DRAIN: state_nxt = (inflight != '0) ? S_DRAIN : (step == LAST_STEP) ? S_DONE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            path         <= '0;
            step         <= '0;
            inflight     <= '0;
            wptr         <= '0;
            rptr         <= '0;
            s0_q         <= '0;
            gbm_valid_in <= 1'b0;
            gbm_z        <= '0;
            gbm_s0       <= '0;
            gbm_r        <= '0;
            gbm_sigma    <= '0;
            gbm_t        <= '0;
            res_valid    <= 1'b0;
            res_path     <= '0;
            res_step     <= '0;
            res_price    <= '0;
            err          <= 1'b0;
        end else begin
            gbm_valid_in <= fire;
            res_valid    <= pop;
            inflight     <= inflight + IW'(fire) - IW'(pop);
            if (fire) begin
                gbm_z  <= z_issue;
                gbm_s0 <= (step == '0) ? s0_q : price[path];
                path   <= (path == LAST_PATH) ? '0 : path + 1'b1;
                wptr   <= (wptr == LAST_SLOT) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr      <= (rptr == LAST_SLOT) ? '0 : rptr + 1'b1;
                res_path  <= tag_mem[rptr];
                res_step  <= step;
                res_price <= gbm_s1;
            end
            if (gbm_valid_out && inflight == '0) err <= 1'b1;
            if (state == S_DRAIN && inflight == '0 && step != LAST_STEP) step <= step + 1'b1;
            if (state == S_IDLE && start) begin
                s0_q      <= cfg_s0;
                gbm_r     <= cfg_r;
                gbm_sigma <= cfg_sigma;
                gbm_t     <= cfg_dt;
                step      <= '0;
                path      <= '0;
                err       <= 1'b0;
            end
        end

    always_ff @(posedge clk) begin
        if (fire) tag_mem[wptr] <= path;
        if (pop) price[tag_mem[rptr]] <= gbm_s1;
    end
endmodule

// File: tb/tb_gbm_path_scheduler.sv
// tb_gbm_path_scheduler: directed checks of issue timing, credit limit, step chaining,
// z backpressure, spurious returns and mid-run reset against an S1 = S0 + 1.0 GBM model.
module tb_gbm_path_scheduler;
    localparam int NP = 8, NS = 3, MI = 4;
    localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef GBM_SCHED_ANTITHETIC_EN
    localparam int ZR_EXP = MI / 2;
`else
    localparam int ZR_EXP = MI;
`endif

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [31:0] cfg_s0 = '0, cfg_r = '0, cfg_sigma = '0, cfg_dt = '0;
    logic        z_valid = 1'b0, z_ready;
    logic [31:0] z_data = '0;
    logic        gbm_valid_in, gbm_valid_out, mdl_v = 1'b0, spur_v = 1'b0;
    logic [31:0] gbm_z, gbm_s0, gbm_r, gbm_sigma, gbm_t, gbm_s1 = '0;
    logic        res_valid, busy, done, err;
    logic [2:0]  res_path;
    logic [1:0]  res_step;
    logic [31:0] res_price;

    assign gbm_valid_out = mdl_v | spur_v;
    always #5 clk = ~clk;

    gbm_path_scheduler #(.WIDTH(32), .N_PATHS(NP), .N_STEPS(NS), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_s0(cfg_s0), .cfg_r(cfg_r), .cfg_sigma(cfg_sigma), .cfg_dt(cfg_dt),
        .z_valid(z_valid), .z_data(z_data), .z_ready(z_ready),
        .gbm_valid_in(gbm_valid_in), .gbm_z(gbm_z), .gbm_s0(gbm_s0),
        .gbm_r(gbm_r), .gbm_sigma(gbm_sigma), .gbm_t(gbm_t),
        .gbm_valid_out(gbm_valid_out), .gbm_s1(gbm_s1),
        .res_valid(res_valid), .res_path(res_path), .res_step(res_step), .res_price(res_price),
        .busy(busy), .done(done), .err(err)
    );

    int total = 0, bad = 0, cyc = 0, lat = 3, zmode = 0, sc = 0;
    int n_iss = 0, n_res = 0, zr_early = 0, iss_first = -1, max_out = 0, done_cyc = -1;
    logic [31:0] zval = '0;
    logic        hs_prev = 1'b0;
    logic [31:0] iss_z [64], iss_s0 [64], rs_path [64], rs_step [64], rs_price [64];
    int          iss_cyc [64], rs_cyc [64];
    typedef struct {int due; logic [31:0] v;} ret_t;
    ret_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // z source, event log and in-order fixed-latency GBM model, all sampled mid-cycle
    always @(negedge clk) begin
        if (hs_prev) zval = zval + 1;
        z_valid = (zmode == 2) ? !z_valid : (zmode == 1);
        z_data  = zval;
        hs_prev = z_ready && z_valid;
        if (z_ready && !res_valid && n_res == 0) zr_early++;
        if (res_valid && n_res == 0) iss_first = n_iss;
        if (gbm_valid_in) begin
            if (n_iss < 64) begin
                iss_z[n_iss]   = gbm_z;
                iss_s0[n_iss]  = gbm_s0;
                iss_cyc[n_iss] = cyc;
            end
            n_iss++;
            q.push_back(ret_t'{cyc + lat, gbm_s0 + ONE});
        end
        if (res_valid) begin
            if (n_res < 64) begin
                rs_path[n_res]  = 32'(res_path);
                rs_step[n_res]  = 32'(res_step);
                rs_price[n_res] = res_price;
                rs_cyc[n_res]   = cyc;
            end
            n_res++;
        end
        if (done) done_cyc = cyc;
        if (n_iss - n_res > max_out) max_out = n_iss - n_res;
        mdl_v = 1'b0;
        if (q.size() > 0 && q[0].due <= cyc) begin
            mdl_v  = 1'b1;
            gbm_s1 = q[0].v;
            q.delete(0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] exp_z(input logic [31:0] seed, input int k);
`ifdef GBM_SCHED_ANTITHETIC_EN
        logic [31:0] v;
        v = seed + 32'(k / 2);
        if (k % 2 == 0) return v;
        return (v == 32'h8000_0000) ? 32'h7FFF_FFFF : -v;
`else
        return seed + 32'(k);
`endif
    endfunction

    task automatic clear_logs();
        n_iss = 0; n_res = 0; zr_early = 0; iss_first = -1; max_out = 0; done_cyc = -1;
    endtask

    task automatic check_zero(input string nm);
        check({nm, ".z_ready"}, 32'(z_ready), 0);
        check({nm, ".gbm_valid_in"}, 32'(gbm_valid_in), 0);
        check({nm, ".res_valid"}, 32'(res_valid), 0);
        check({nm, ".busy"}, 32'(busy), 0);
        check({nm, ".done"}, 32'(done), 0);
        check({nm, ".err"}, 32'(err), 0);
        check({nm, ".gbm_z"}, gbm_z, 0);
        check({nm, ".gbm_s0"}, gbm_s0, 0);
        check({nm, ".gbm_r"}, gbm_r, 0);
        check({nm, ".gbm_t"}, gbm_t, 0);
        check({nm, ".res_path"}, 32'(res_path), 0);
        check({nm, ".res_step"}, 32'(res_step), 0);
        check({nm, ".res_price"}, res_price, 0);
    endtask

    // called on a falling edge; cfg inputs are scrambled after start to prove they were latched
    task automatic launch(input logic [31:0] s0, input logic [31:0] seed, input int l, input int m);
        clear_logs();
        lat = l; zmode = m; zval = seed; z_data = seed;
        cfg_s0 = s0; cfg_r = 32'h0000_0CCD; cfg_sigma = 32'h0000_3333; cfg_dt = 32'h0000_1000;
        start = 1'b1; sc = cyc;
        tick(1);
        start = 1'b0;
        cfg_s0 = ~s0; cfg_r = 32'hDEAD_0001; cfg_sigma = 32'hDEAD_0002; cfg_dt = 32'hDEAD_0003;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 3000) begin
            tick(1);
            k++;
        end
        check({nm, ".done_seen"}, 32'(done), 1);
        tick(1);
        check({nm, ".busy_drop"}, 32'(busy), 0);
        check({nm, ".done_pulse"}, 32'(done), 0);
    endtask

    task automatic check_run(input string nm, input logic [31:0] s0, input logic [31:0] seed);
        check({nm, ".n_iss"}, 32'(n_iss), NP * NS);
        check({nm, ".n_res"}, 32'(n_res), NP * NS);
        for (int i = 0; i < NP * NS && i < n_iss; i++) begin
            check($sformatf("%s.gbm_z[%0d]", nm, i), iss_z[i], exp_z(seed, i));
            check($sformatf("%s.gbm_s0[%0d]", nm, i), iss_s0[i], s0 + ONE * 32'(i / NP));
        end
        for (int i = 0; i < NP * NS && i < n_res; i++) begin
            check($sformatf("%s.res_path[%0d]", nm, i), rs_path[i], 32'(i % NP));
            check($sformatf("%s.res_step[%0d]", nm, i), rs_step[i], 32'(i / NP));
            check($sformatf("%s.res_price[%0d]", nm, i), rs_price[i], s0 + ONE * 32'(i / NP + 1));
        end
        if (n_iss >= NP * NS && n_res >= NP * NS) begin
            for (int s = 1; s < NS; s++)
                check($sformatf("%s.barrier[%0d]", nm, s), 32'(iss_cyc[s * NP] > rs_cyc[s * NP - 1]), 1);
            check({nm, ".done_lag"}, 32'(done_cyc - rs_cyc[NP * NS - 1]), 1);
        end
        check({nm, ".gbm_r"}, gbm_r, 32'h0000_0CCD);
        check({nm, ".gbm_sigma"}, gbm_sigma, 32'h0000_3333);
        check({nm, ".gbm_t"}, gbm_t, 32'h0000_1000);
        check({nm, ".max_out"}, 32'(max_out <= MI), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        tick(2);
        check_zero("reset");
        rst_n = 1'b1;
        tick(2);
        check_zero("idle");

        launch(32'h000A_0000, 32'h0000_8000, 3, 1);
        wait_done("A");
        check("A.issue0_cycle", 32'(iss_cyc[0] - sc), 2);
        check("A.issue1_cycle", 32'(iss_cyc[1] - sc), 3);
        check("A.err", 32'(err), 0);
        check_run("A", 32'h000A_0000, 32'h0000_8000);

        launch(32'h0002_0000, 32'h1234_0000, 20, 1);
        wait_done("B");
        check("B.issues_before_ret", 32'(iss_first), MI);
        check("B.zready_before_ret", 32'(zr_early), ZR_EXP);
        check("B.peak_inflight", 32'(max_out), MI);
        check_run("B", 32'h0002_0000, 32'h1234_0000);

        launch(32'h0100_0000, 32'h7FFF_FFFE, 3, 2);
        wait_done("C");
        check_run("C", 32'h0100_0000, 32'h7FFF_FFFE);
        zmode = 0;

        tick(1);
        clear_logs();
        spur_v = 1'b1;
        tick(1);
        spur_v = 1'b0;
        tick(1);
        check("D.err", 32'(err), 1);
        tick(2);
        check("D.err_sticky", 32'(err), 1);
        check("D.no_res", 32'(n_res), 0);
        check("D.idle", 32'(busy), 0);

        launch(32'h0003_0000, 32'h0000_0100, 10, 1);
        tick(3);
        check("E.busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        zmode = 0;
        tick(1);
        check_zero("E.reset");
        rst_n = 1'b1;
        tick(12);
        check("E.late_err", 32'(err), 1);
        check("E.no_res", 32'(n_res), 0);
        check("E.idle", 32'(busy), 0);

        launch(32'h000A_0000, 32'h0000_0040, 3, 1);
        check("F.err_cleared", 32'(err), 0);
        wait_done("F");
        check("F.err_end", 32'(err), 0);
        check_run("F", 32'h000A_0000, 32'h0000_0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
